// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and keeps the two most recently accepted hex key codes.
module keypad_scanner #(
    parameter int SCAN_DIV       = 12_000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic       key_valid
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t        state, state_d;
    logic [3:0]    rows_q1, rs;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [DW-1:0] db;
    logic [1:0]    col_idx, row_idx, first_row;
    logic          row_lvl;
    logic          latch_row, col_adv, db_inc, accept;
    logic [3:0]    key_code;

    // Two-flop synchronizer; idle (all released) value is all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_q1 <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rows_q1 <= rows;
            rs      <= rows_q1;
        end
    end

    // Free-running scan tick divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              cnt <= '0;
        else if (cnt == CNT_MAX) cnt <= '0;
        else                     cnt <= cnt + CW'(1);
    end

    assign tick    = (cnt == CNT_MAX);
    assign row_lvl = rs[row_idx];

    // Lowest active row wins when several rows are low in one column
    always_comb begin
        first_row = 2'd3;
        if      (!rs[0]) first_row = 2'd0;
        else if (!rs[1]) first_row = 2'd1;
        else if (!rs[2]) first_row = 2'd2;
    end

    // Hex code for the latched (row, col) coordinate
    always_comb begin
        case ({row_idx, col_idx})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;  4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;  default: key_code = 4'hD;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SCAN;
        else        state <= state_d;
    end

    // FSM next-state logic; every transition waits for a scan tick
    always_comb begin
        state_d = state;
        if (tick) begin
            case (state)
                SCAN:       if (rs != 4'hF) state_d = PRESS_DB;
                PRESS_DB:   if (row_lvl) state_d = SCAN;
                            else if (db == DB_LAST) state_d = HELD;
                HELD:       if (row_lvl) state_d = RELEASE_DB;
                RELEASE_DB: if (!row_lvl) state_d = HELD;
                            else if (db == DB_LAST) state_d = SCAN;
                default:    state_d = SCAN;
            endcase
        end
    end

    // FSM output strobes driving the datapath registers
    always_comb begin
        latch_row = 1'b0;
        col_adv   = 1'b0;
        db_inc    = 1'b0;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (rs != 4'hF) latch_row = 1'b1;
                    else            col_adv   = 1'b1;
                end
                PRESS_DB: begin
                    if (!row_lvl) begin
                        if (db == DB_LAST) accept = 1'b1;
                        else               db_inc = 1'b1;
                    end
                end
                RELEASE_DB: begin
                    if (row_lvl) begin
                        if (db == DB_LAST) col_adv = 1'b1;
                        else               db_inc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Debounce counter restarts on every state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                db <= '0;
        else if (state_d != state) db <= '0;
        else if (db_inc)           db <= db + DW'(1);
    end

    // Scan position, latched row, digit history and accept pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            s0        <= 4'h0;
            s1        <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= accept;
            if (col_adv)   col_idx <= col_idx + 2'd1;
            if (latch_row) row_idx <= first_row;
            if (accept) begin
                s1 <= s0;
                s0 <= key_code;
            end
        end
    end

    // One-cold column drive decoded from the registered scan position
    always_comb cols = ~(4'b0001 << col_idx);

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses and releases, and maintains the two most recently pressed hex digits. Sits directly upstream of the dual seven-segment multiplexer: `s0` feeds its first digit input (newest key) and `s1` its second digit input (previous key). It runs from the same 12 MHz board clock and reset.

## Interface

- `SCAN_DIV`, default 12_000: clk cycles per scan tick, giving 1 kHz at 12 MHz. Legal range is ≥ 4.
- `DEBOUNCE_TICKS`, default 20: consecutive ticks a level must persist to be accepted. Legal range is ≥ 1.
- `clk`  in  1  board clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rows`  in  4  keypad row lines, active-low (externally pulled up), asynchronous to `clk`.
- `cols`  out  4  column drive, active-low, exactly one bit low at all times.
- `s0`  out  4  most recently accepted key code.
- `s1`  out  4  key code accepted before `s0`.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.

## Operation

**Key map.** Coordinates are given as (row, col), with col 0 leftmost.
- Row 0: 1, 2, 3, A.
- Row 1: 4, 5, 6, B.
- Row 2: 7, 8, 9, C.
- Row 3: E, 0, F, D.

**Synchronizer.** `rows` passes through a 2-flop synchronizer, reset to 4'hF. All decisions use the synchronized value `rs`.

**Tick counter.** The counter runs 0..SCAN_DIV-1 and wraps. `tick` is asserted on the cycle the count equals SCAN_DIV-1. The counter free-runs in every state.

**Column drive.** `cols = ~(4'b0001 << col_idx)`, where `col_idx` is 2 bits and wraps 3→0.

**FSM states:** SCAN, PRESS_DB, HELD, RELEASE_DB. A debounce counter `db` is cleared on every state entry. All transitions occur only on `tick`.
- **SCAN.**
  - If `rs != 4'hF`: latch `row_idx` = lowest index with `rs[i]==0`, keep `col_idx`, and go to PRESS_DB.
  - Otherwise: advance `col_idx`.
- **PRESS_DB.**
  - If `rs[row_idx]==0`: increment `db`. When `db` reaches DEBOUNCE_TICKS, accept the key and go to HELD.
  - If `rs[row_idx]==1`: return to SCAN with `col_idx` unchanged.
- **Accept.** On the same clock edge as the transition:
  - `s1 <= s0`.
  - `s0 <= map(row_idx, col_idx)`.
  - `key_valid <= 1`.
- **HELD.**
  - If `rs[row_idx]==1`: go to RELEASE_DB.
  - Other rows are ignored. There is no auto-repeat.
- **RELEASE_DB.**
  - If `rs[row_idx]==1`: increment `db`. When `db` reaches DEBOUNCE_TICKS, advance `col_idx` and go to SCAN.
  - If `rs[row_idx]==0` (bounce): return to HELD.

**Multi-key behaviour.**
- Only the first detected key is registered.
- A second key pressed while the first is held is never registered, even after the first is released, unless the second key is re-pressed or is detected on a later scan after release.
- Simultaneous rows in one column resolve to the lowest row index.

**Reset** (asynchronous, any state, mid-debounce included):
- `s0 = s1 = 4'h0`.
- `key_valid = 0`.
- `col_idx = 0`, so `cols = 4'b1110`.
- State = SCAN; `db`, tick counter and synchronizer all cleared (synchronizer to 4'hF).

## Timing

- All outputs are registered; there are no combinational paths from `rows` to any output.
- **Input latency.** A `rows` change reaches `rs` in 2 cycles.
- **Press-to-accept latency.** If the press is first seen on tick T0, `key_valid` is high for exactly one cycle, on the cycle after tick T0 + DEBOUNCE_TICKS. `s0`/`s1` update on the same edge and then hold.
- **Column hold.** `cols` changes only on a tick edge, so each column is driven for SCAN_DIV cycles before it is sampled.
- **Minimum re-accept spacing.** At least 2·DEBOUNCE_TICKS + 1 ticks between two accepts.
- **Width.** `db` must be wide enough for DEBOUNCE_TICKS with no overflow. The tick counter is sized from SCAN_DIV.

## Test plan

Simulate with SCAN_DIV=4 and DEBOUNCE_TICKS=3.

- **Reset.** Hold reset low for 5 cycles, then release → `cols`=1110, `s0`=`s1`=0, `key_valid`=0. After release, `cols` steps 1110→1101→1011→0111→1110, one step every 4 cycles.
- **Single press.** Pull row 1 low only while `cols`=1011 (key 6) and hold it for 20 ticks → one `key_valid` pulse, `s0`=6, `s1`=0. `cols` stays at 1011 until 3 ticks after release.
- **Digit shift.** Press and release 5, then press and release A → after the second accept, `s0`=A and `s1`=5. Exactly two `key_valid` pulses.
- **Press bounce.** Row 0 low for 1 tick, high for 1 tick, low for 1 tick, then held → no accept until 3 consecutive low ticks. Exactly one pulse in total.
- **Release bounce and held second key.** Hold key 1. Glitch row 0 high for 1 tick, then back low → no new `key_valid`. While 1 is held, press key 9 → ignored. Release both → `s0`=1.
- **Reset mid-debounce.** Assert reset during PRESS_DB with `db`=2 → all outputs return to reset values immediately. No `key_valid` pulse appears after reset is released while the key is still held, until a fresh 3-tick debounce completes.
